// File: rtl/crtc_timing_gen_if.sv
// Host bus of the CRTC: index/data register strobes plus read-back data.
interface crtc_timing_gen_if;
  logic       cs;
  logic       a0;
  logic       write;
  logic       read;
  logic [7:0] bus;
  logic [7:0] bus_out;

  modport master (output cs, a0, write, read, bus, input bus_out);
  modport slave  (input cs, a0, write, read, bus, output bus_out);
endinterface

// File: rtl/crtc_timing_gen.sv
// CRTC timing generator: character/scanline/row counters, sync and blank
// generation, display memory addressing, cursor and light-pen capture.
module crtc_timing_gen #(
  parameter int H_W        = 8,
  parameter int MA_W       = 14,
  parameter int RA_W       = 5,
  parameter int HBLANK_DLY = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            divclk,
  crtc_timing_gen_if.slave bus_if,
  input  logic            lock,
  input  logic            lpen_stb,
  output logic            hsync,
  output logic            vsync,
  output logic            hblank,
  output logic            vblank,
  output logic            display_enable,
  output logic            cursor,
  output logic [MA_W-1:0] mem_addr,
  output logic [RA_W-1:0] row_addr,
  output logic            line_reset,
  output logic            frame_start
);
  localparam int HI_W = MA_W - 8;

  logic [4:0]      index;
  logic [H_W-1:0]  r0, r1, r2;
  logic [7:0]      r3, r8;
  logic [6:0]      r4, r5, r6, r7, r10;
  logic [RA_W-1:0] r9, r11;
  logic [HI_W-1:0] r12, r14, r16;
  logic [7:0]      r13, r15, r17;

  logic [H_W-1:0]  h_count;
  logic [6:0]      row;
  logic [RA_W-1:0] scan;
  logic [4:0]      blink_cnt;
  logic [MA_W-1:0] row_base;
  logic [3:0]      hs_left, vs_left;
  logic [2:0]      lp_sync;
  logic [HBLANK_DLY-1:0] hb_pipe;
  logic [7:0]      rd_data;

  logic wr_idx, wr_data, lp_rise, line_end, last_row, row_end, frame_hit;
  logic hs_start, vs_start, h_vis, blink;
  logic unused_read;

  assign unused_read = bus_if.read;
  assign wr_idx  = bus_if.cs & bus_if.write & ~bus_if.a0;
  assign wr_data = bus_if.cs & bus_if.write & bus_if.a0;
  assign lp_rise = lp_sync[1] & ~lp_sync[2];

  assign line_end  = divclk & (h_count == r0);
  assign last_row  = (row == r4);
  assign row_end   = (scan == r9);
  // The last row is stretched by R5 adjust scanlines before the frame wraps.
  assign frame_hit = last_row & (8'(scan) == (8'(r9) + 8'(r5)));
  assign hs_start  = (h_count == r2) & (r2 <= r0);
  assign vs_start  = (row == r7) & (scan == '0);
  assign h_vis     = (h_count < r1);

  assign line_reset     = line_end;
  assign frame_start    = line_end & frame_hit;
  assign hsync          = hs_start | (hs_left != 4'd0);
  assign vsync          = vs_start | (vs_left != 4'd0);
  assign display_enable = h_vis & (row < r6);
  assign vblank         = ~(row < r6);
  assign hblank         = hb_pipe[HBLANK_DLY-1];
  assign row_addr       = scan;
  assign mem_addr       = {r12, r13} + row_base + MA_W'(h_count);

  // Blink source selected by the cursor-start register's mode bits.
  always_comb begin
    case (r10[6:5])
      2'b00:   blink = 1'b1;
      2'b01:   blink = 1'b0;
      2'b10:   blink = blink_cnt[3];
      default: blink = blink_cnt[4];
    endcase
  end

  assign cursor = (mem_addr == {r14, r15}) & display_enable & blink &
                  (8'(r10[4:0]) <= 8'(scan)) & (8'(scan) <= 8'(r11));

  // Combinational register read-back; unmapped indices read as zero.
  always_comb begin
    rd_data = 8'h00;
    case (index)
      5'd0:  rd_data = 8'(r0);
      5'd1:  rd_data = 8'(r1);
      5'd2:  rd_data = 8'(r2);
      5'd3:  rd_data = r3;
      5'd4:  rd_data = 8'(r4);
      5'd5:  rd_data = 8'(r5);
      5'd6:  rd_data = 8'(r6);
      5'd7:  rd_data = 8'(r7);
      5'd8:  rd_data = r8;
      5'd9:  rd_data = 8'(r9);
      5'd10: rd_data = 8'(r10);
      5'd11: rd_data = 8'(r11);
      5'd12: rd_data = 8'(r12);
      5'd13: rd_data = r13;
      5'd14: rd_data = 8'(r14);
      5'd15: rd_data = r15;
      5'd16: rd_data = 8'(r16);
      5'd17: rd_data = r17;
      default: rd_data = 8'h00;
    endcase
  end
  assign bus_if.bus_out = rd_data;

  // Register file writes and light-pen address capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= '0;
      r0 <= H_W'(97); r1 <= H_W'(80); r2 <= H_W'(82); r3 <= 8'h0F;
      r4 <= 7'd25; r5 <= 7'd6; r6 <= 7'd25; r7 <= 7'd25; r8 <= 8'h00;
      r9 <= RA_W'(13); r10 <= 7'd11; r11 <= RA_W'(12);
      r12 <= '0; r13 <= '0; r14 <= '0; r15 <= '0; r16 <= '0; r17 <= '0;
    end else begin
      if (wr_idx) index <= bus_if.bus[4:0];
      if (wr_data && !(lock && index <= 5'd9)) begin
        case (index)
          5'd0:  r0  <= H_W'(bus_if.bus);
          5'd1:  r1  <= H_W'(bus_if.bus);
          5'd2:  r2  <= H_W'(bus_if.bus);
          5'd3:  r3  <= bus_if.bus;
          5'd4:  r4  <= bus_if.bus[6:0];
          5'd5:  r5  <= bus_if.bus[6:0];
          5'd6:  r6  <= bus_if.bus[6:0];
          5'd7:  r7  <= bus_if.bus[6:0];
          5'd8:  r8  <= bus_if.bus;
          5'd9:  r9  <= RA_W'(bus_if.bus);
          5'd10: r10 <= bus_if.bus[6:0];
          5'd11: r11 <= RA_W'(bus_if.bus);
          5'd12: r12 <= HI_W'(bus_if.bus);
          5'd13: r13 <= bus_if.bus;
          5'd14: r14 <= HI_W'(bus_if.bus);
          5'd15: r15 <= bus_if.bus;
          default: ;
        endcase
      end
      if (lp_rise) {r16, r17} <= mem_addr;
    end
  end

  // Light-pen synchroniser plus one edge-detect stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lp_sync <= '0;
    else        lp_sync <= {lp_sync[1:0], lpen_stb};
  end

  // Character, scanline, row, blink and row-base counters plus sync width timers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count   <= '0;
      row       <= '0;
      scan      <= '0;
      blink_cnt <= '0;
      row_base  <= '0;
      hs_left   <= '0;
      vs_left   <= '0;
    end else if (divclk) begin
      h_count <= line_end ? '0 : h_count + H_W'(1);
      if (hs_start)             hs_left <= r3[3:0] - 4'd1;
      else if (hs_left != 4'd0) hs_left <= hs_left - 4'd1;
      if (line_end) begin
        if (vs_start)             vs_left <= r3[7:4] - 4'd1;
        else if (vs_left != 4'd0) vs_left <= vs_left - 4'd1;
        if (frame_hit) begin
          row       <= '0;
          scan      <= '0;
          blink_cnt <= blink_cnt + 5'd1;
          row_base  <= '0;
        end else begin
          if (row_end) row_base <= row_base + MA_W'(r1);
          if (row_end && !last_row) begin
            scan <= '0;
            row  <= row + 7'd1;
          end else begin
            scan <= scan + RA_W'(1);
          end
        end
      end
    end
  end

  // Horizontal blank is the inverted visible window delayed through a pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hb_pipe <= '0;
    else begin
      hb_pipe[0] <= ~h_vis;
      for (int i = 1; i < HBLANK_DLY; i++) hb_pipe[i] <= hb_pipe[i-1];
    end
  end
endmodule
